// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions for the skid-buffered register stage.
package pipe_skid_reg_pkg;

   localparam int unsigned OCC_W   = 2;
   localparam int unsigned STALL_W = 16;

   typedef enum logic [OCC_W-1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (v == '1) ? v : v + STALL_W'(1);
   endfunction

endpackage

// File: rtl/pipe_skid_flop.sv
// Load-enable data register with asynchronous active-low reset to a constant.
module pipe_skid_flop #(
   parameter int unsigned           WIDTH     = 8,
   parameter logic [WIDTH-1:0]      RESET_VAL = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready register slice: main register drives the output,
// skid register absorbs the one item that arrives while downstream stalls.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   input  logic               flush,
   output logic [OCC_W-1:0]   occupancy,
   output logic [STALL_W-1:0] stall_cnt
);

   occ_e               occ_q, occ_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               main_en, skid_en, main_from_skid;
   logic               in_xfer, out_xfer;
   logic [WIDTH-1:0]   main_d, main_q, skid_q;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = out_valid_q & out_ready;

   // Next-state and data-path steering.
   always_comb begin
      occ_d          = occ_q;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      stall_d        = (out_valid_q && !out_ready) ? sat_inc(stall_q) : stall_q;

      case (occ_q)
         OCC_EMPTY: begin
            if (in_xfer) begin
               main_en = 1'b1;
               occ_d   = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (in_xfer && out_xfer) begin
               main_en = 1'b1;
            end else if (in_xfer) begin
               skid_en = 1'b1;
               occ_d   = OCC_FULL;
            end else if (out_xfer) begin
               occ_d   = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (out_xfer) begin
               main_en        = 1'b1;
               main_from_skid = 1'b1;
               occ_d          = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase

      // Flush drops validity only; data registers keep their contents.
      if (flush) begin
         occ_d   = OCC_EMPTY;
         main_en = 1'b0;
         skid_en = 1'b0;
      end

      out_valid_d = (occ_d != OCC_EMPTY);
      in_ready_d  = (occ_d != OCC_FULL);
   end

   // in_ready resets low so nothing is accepted until one edge after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q       <= OCC_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         stall_q     <= '0;
      end else begin
         occ_q       <= occ_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         stall_q     <= stall_d;
      end
   end

   assign main_d = main_from_skid ? skid_q : in_data;

   pipe_skid_flop #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
      .clk (clk),
      .rst (rst),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
   );

   pipe_skid_flop #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
      .clk (clk),
      .rst (rst),
      .en  (skid_en),
      .d   (in_data),
      .q   (skid_q)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = occ_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue reference model checked every cycle plus directed literal checks.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        flush = 1'b0;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h01)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the held items as a plain FIFO queue.
   logic [7:0] mq[$];
   int         m_stall = 0;
   bit         m_hold  = 1'b1;
   bit         m_rdy, m_in_acc, m_out_acc;
   int         m_pops  = 0;
   int         m_pushes = 0;
   int         d_pops  = 0;
   bit         seen_cc = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_stall = 0;
         m_hold  = 1'b1;
      end else begin
         if (out_valid && out_ready) d_pops++;
         m_rdy     = !m_hold && (mq.size() < 2);
         m_in_acc  = in_valid && m_rdy;
         m_out_acc = (mq.size() > 0) && out_ready;
         if ((mq.size() > 0) && !out_ready && m_stall < 65535) m_stall++;
         if (m_out_acc) begin
            void'(mq.pop_front());
            m_pops++;
         end
         if (flush) begin
            mq.delete();
         end else if (m_in_acc) begin
            mq.push_back(in_data);
            m_pushes++;
         end
         m_hold = 1'b0;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_occupancy", int'(occupancy), 0);
         chk("rst_in_ready",  int'(in_ready),  0);
         chk("rst_stall_cnt", int'(stall_cnt), 0);
         chk("rst_out_data",  int'(out_data),  32'h01);
      end else begin
         chk("out_valid", int'(out_valid), int'(mq.size() > 0));
         chk("occupancy", int'(occupancy), int'(mq.size()));
         chk("in_ready",  int'(in_ready),  int'(!m_hold && (mq.size() < 2)));
         chk("stall_cnt", int'(stall_cnt), m_stall);
         if (mq.size() > 0) chk("out_data", int'(out_data), int'(mq[0]));
         if (out_valid && out_data == 8'hCC) seen_cc = 1'b1;
      end
   end

   task automatic step(input bit iv, input logic [7:0] id, input bit ordy, input bit fl);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b0;
      // Reset held for three cycles.
      repeat (3) step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("lit_rst_out_valid", int'(out_valid), 0);
      chk("lit_rst_occ",       int'(occupancy), 0);
      chk("lit_rst_out_data",  int'(out_data),  32'h01);
      chk("lit_rst_stall",     int'(stall_cnt), 0);
      chk("lit_rst_in_ready",  int'(in_ready),  0);
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lit_in_ready_after_rst", int'(in_ready), 1);

      // Streaming 10..1F with downstream always ready.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
         chk("lit_stream_valid", int'(out_valid), 1);
         chk("lit_stream_data",  int'(out_data),  int'(8'h10) + i);
         chk("lit_stream_occ_le1", int'(occupancy <= 2'd1), 1);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lit_stream_drained", int'(out_valid), 0);

      // Backpressure: two items, four stalled cycles.
      step(1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b0);
      chk("lit_bp_occ",      int'(occupancy), 2);
      chk("lit_bp_in_ready", int'(in_ready),  0);
      repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("lit_bp_stall",    int'(stall_cnt), 4);
      chk("lit_bp_head",     int'(out_data),  32'hA1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lit_bp_second",   int'(out_data),  32'hA2);
      chk("lit_bp_in_ready_back", int'(in_ready), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lit_bp_empty",    int'(occupancy), 0);

      // Flush while full, with an offered item that must never show up.
      step(1'b1, 8'hB1, 1'b0, 1'b0);
      step(1'b1, 8'hB2, 1'b0, 1'b0);
      chk("lit_fl_full", int'(occupancy), 2);
      step(1'b1, 8'hCC, 1'b0, 1'b1);
      chk("lit_fl_occ",       int'(occupancy), 0);
      chk("lit_fl_out_valid", int'(out_valid), 0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lit_fl_no_cc",     int'(seen_cc),   0);
      chk("lit_fl_stall_kept", int'(stall_cnt), 6);

      // Saturation of the stall counter.
      step(1'b1, 8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("lit_sat_stall", int'(stall_cnt), 32'hFFFF);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lit_sat_hold", int'(stall_cnt), 32'hFFFF);

      // Random traffic with a mid-run reset.
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) rst = 1'b0;
         if (i == 5002) rst = 1'b1;
         step(1'($urandom_range(0, 1)), 8'($urandom),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 63) == 0));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rand_pop_count", d_pops, m_pops);
      chk("rand_drained",   int'(out_valid), 0);
      chk("rand_activity",  int'(m_pushes > 2000), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits.
REQ-002 Parameter RESET_VAL, default 1: value loaded into every data register at reset.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  out_data holds a valid item.
REQ-009 out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 out_data  output  WIDTH  head item.
REQ-011 flush  input  1  synchronous discard of all held items.
REQ-012 occupancy  output  2  items held, 0..2.
REQ-013 stall_cnt  output  16  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both on the same posedge.
REQ-015 Storage: main register (drives out_data/out_valid) and skid register; strict FIFO order, no item dropped or duplicated.
REQ-016 in_ready = !skid_valid, driven from a flop only, with no combinational path from out_ready.
REQ-017 out_data/out_valid driven from flops only; latency in_data -> out_data is 1 cycle when empty.
REQ-018 Empty (occ 0): accept loads main; occ becomes 1.
REQ-019 occ 1: accept without out-transfer loads skid, occ 2, in_ready falls next cycle; accept with out-transfer loads main, occ stays 1; out-transfer alone gives occ 0.
REQ-020 Full (occ 2): in_ready=0; out-transfer moves skid to main, occ 1, in_ready rises next cycle.
REQ-021 Back-to-back throughput is one item per cycle while out_ready stays 1.
REQ-022 flush=1: both valids clear and occ becomes 0 next cycle; a simultaneous in-transfer is discarded; the out-transfer of that cycle still counts as consumed; data registers keep their values.
REQ-023 stall_cnt increments each cycle with out_valid=1 & out_ready=0 and saturates at 16'hFFFF; flush does not clear it.
REQ-024 in_data is ignored when in_valid=0; out_data is don't-care when out_valid=0 but never X after reset.

Reset
REQ-025 rst=0 asynchronously forces out_valid=0, skid_valid=0, occupancy=0, stall_cnt=0, main and skid data = RESET_VAL.
REQ-026 in_ready is 0 while rst=0 and becomes 1 on the first posedge after rst deasserts.
REQ-027 Reset in mid-operation discards all held items; no transfer completes in that cycle.

Structure
REQ-028 The occupancy encodings (EMPTY=0, ONE=1, FULL=2) and the stall_cnt width constant (16) belong in the shared pipeline package.
REQ-029 The data registers use one sub-module, pipe_skid_flop: WIDTH-wide load-enable flop with asynchronous active-low reset to RESET_VAL, instantiated twice.

Verification
REQ-030 Reset: hold rst=0 for 3 cycles -> out_valid=0, occ=0, out_data=8'h01, stall_cnt=0, in_ready=0; one cycle after release in_ready=1.
REQ-031 Streaming: out_ready=1, push 8'h10..8'h1F on consecutive cycles -> same sequence on out_data one cycle later, no bubbles, occ never exceeds 1.
REQ-032 Backpressure: push 8'hA1, 8'hA2 with out_ready=0 -> occ=2, in_ready=0; hold 4 cycles -> stall_cnt=4 (after the first item lands); release -> A1 then A2, in_ready=1 one cycle after A1 leaves.
REQ-033 Flush at full: occ=2, assert flush with in_valid=1 carrying 8'hCC -> next cycle occ=0, out_valid=0, 8'hCC never appears.
REQ-034 Saturation: force 70000 stalled cycles -> stall_cnt holds 16'hFFFF.
REQ-035 Random valid/ready (10k cycles) against a reference queue model -> order and count match, no loss.
